// File: rtl/dffram_arbiter_if.sv
// Requester-side bundle for one port of the DFFRAM arbiter.
// The requester drives the transfer; the arbiter returns the grant and the read response.
interface dffram_arbiter_if;
  logic        valid;
  logic        ready;
  logic [3:0]  we;
  logic [7:0]  a;
  logic [31:0] di;
  logic        lock;
  logic        rvalid;
  logic [31:0] dout;

  modport master (
    output valid, we, a, di, lock,
    input  ready, rvalid, dout
  );

  modport slave (
    input  valid, we, a, di, lock,
    output ready, rvalid, dout
  );
endinterface

// File: rtl/dffram_arbiter.sv
// Two-port arbiter in front of a single-port DFFRAM: round-robin or fixed priority,
// with per-port bus locking and an idle-owner timeout that forcibly releases a lock.
module dffram_arbiter #(
  parameter bit          FIXED_PRIO   = 1'b0,
  parameter int unsigned LOCK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  dffram_arbiter_if.slave  p0,
  dffram_arbiter_if.slave  p1,
  output logic [3:0]       we0,
  output logic             en0,
  output logic [7:0]       a0,
  output logic [31:0]      di0,
  input  logic [31:0]      do0,
  output logic             lock_err
);

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  localparam logic [7:0] IDLE_LIMIT = 8'(LOCK_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;   // 1: port 1 was granted most recently
  logic [7:0]  idle_q, idle_d;
  logic        rvalid0_q, rvalid1_q;
  logic        grant0, grant1;

  // NOTE: every variable gets a default before any branch, so no path can infer a latch.
  always_comb begin
    grant0   = 1'b0;
    grant1   = 1'b0;
    state_d  = state_q;
    last_d   = last_q;
    idle_d   = idle_q;
    lock_err = 1'b0;

    if (!rst) begin
      case (state_q)
        FREE: begin
          if (p0.valid && p1.valid) begin
            if (FIXED_PRIO || last_q) grant0 = 1'b1;
            else                      grant1 = 1'b1;
          end else begin
            grant0 = p0.valid;
            grant1 = p1.valid;
          end
        end
        LOCK0:   grant0 = p0.valid;
        LOCK1:   grant1 = p1.valid;
        default: ;
      endcase

      if (grant0) begin
        state_d = p0.lock ? LOCK0 : FREE;
        last_d  = 1'b0;
        idle_d  = 8'd0;
      end else if (grant1) begin
        state_d = p1.lock ? LOCK1 : FREE;
        last_d  = 1'b1;
        idle_d  = 8'd0;
      end else if (state_q != FREE) begin
        // Locked and no grant means the owner is idle this cycle.
        if (idle_q == IDLE_LIMIT) begin
          state_d  = FREE;
          idle_d   = 8'd0;
          lock_err = 1'b1;
        end else begin
          idle_d = idle_q + 8'd1;
        end
      end
    end
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FREE;
      last_q    <= 1'b1;
      idle_q    <= 8'd0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      idle_q    <= idle_d;
      rvalid0_q <= grant0 && (p0.we == 4'b0000);
      rvalid1_q <= grant1 && (p1.we == 4'b0000);
    end
  end

  assign p0.ready  = grant0;
  assign p1.ready  = grant1;
  assign p0.rvalid = rvalid0_q;
  assign p1.rvalid = rvalid1_q;
  assign p0.dout   = do0;
  assign p1.dout   = do0;

  // RAM side follows the granted port; address and data are don't-care when idle.
  assign en0 = grant0 | grant1;
  assign we0 = grant1 ? p1.we : (grant0 ? p0.we : 4'b0000);
  assign a0  = grant1 ? p1.a  : p0.a;
  assign di0 = grant1 ? p1.di : p0.di;

endmodule

// File: doc/dffram_arbiter.md
DFFRAM_ARBITER -- requirements
Module: dffram_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0; 0 selects round-robin, 1 gives port 0 strict priority.
REQ-002 Parameter LOCK_TIMEOUT, default 16; idle-owner cycles before a lock is forcibly released (range 2..255).
REQ-003 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-004 RST  in  1  reset; synchronous and active-high.
REQ-005 Pn_VALID  in  1  request from port n (n = 0, 1).
REQ-006 Pn_READY  out  1  grant; the request is accepted when Pn_VALID and Pn_READY are both 1.
REQ-007 Pn_WE  in  4  byte write enables; 0000 means read.
REQ-008 Pn_A  in  8  word address.
REQ-009 Pn_DI  in  32  write data.
REQ-010 Pn_LOCK  in  1  keep the grant after this transfer.
REQ-011 Pn_RVALID  out  1  read data valid on Pn_DO.
REQ-012 Pn_DO  out  32  read data; Do0 passed through unregistered to both ports.
REQ-013 WE0  out  4  RAM byte write enables.
REQ-014 EN0  out  1  RAM enable.
REQ-015 A0  out  8  RAM address.
REQ-016 Di0  out  32  RAM write data.
REQ-017 Do0  in  32  RAM read data, valid one cycle after an EN0=1 read.
REQ-018 LOCK_ERR  out  1  one-cycle pulse when a lock times out.

Function
REQ-019 Arbiter states: FREE, LOCK0, LOCK1.
REQ-020 FREE, one port valid: that port's READY is 1.
REQ-021 FREE, both ports valid, FIXED_PRIO=0: grant goes to the port not granted most recently; after reset, port 0 wins first.
REQ-022 FREE, both ports valid, FIXED_PRIO=1: port 0 always wins.
REQ-023 At most one READY is 1 per cycle; READY is combinational from VALID, state and the round-robin pointer.
REQ-024 On accept, in the same cycle: EN0=1; A0, Di0 and WE0 are taken from the granted port.
REQ-025 With no accept: EN0=0 and WE0=0000; A0 and Di0 are don't-care.
REQ-026 Accepted read (WE=0000): Pn_RVALID=1 exactly one cycle later for the issuing port only.
REQ-027 Accepted write: no RVALID; the RAM updates at the accepting edge.
REQ-028 No back-pressure on responses; a new request may be accepted in the cycle its predecessor's RVALID is high, giving 1 access per cycle sustained.
REQ-029 Accept with Pn_LOCK=1 from FREE or LOCKn: next state is LOCKn.
REQ-030 Accept with Pn_LOCK=0 in LOCKn: next state is FREE.
REQ-031 In LOCKn, the other port's READY is 0 and Pn_READY equals Pn_VALID.
REQ-032 In LOCKn, an 8-bit idle counter increments each cycle Pn_VALID=0 and clears on any accept.
REQ-033 Idle counter reaching LOCK_TIMEOUT-1 while idle: next state FREE, LOCK_ERR pulses one cycle, counter clears.
REQ-034 Timeout and a new owner request never coincide, because a request in that cycle clears the counter first.
REQ-035 The round-robin pointer updates only on accept and records the granted port, including accepts made while locked.
REQ-036 A LOCK input is ignored unless its transfer is accepted.

Reset
REQ-037 RST=1 at an edge forces state FREE, pointer to "port 1 last", idle counter 0, and both RVALID flops 0.
REQ-038 While RST=1: all READY, EN0, WE0 and LOCK_ERR are 0 combinationally, regardless of VALID.
REQ-039 An accept pending at a reset edge produces no RVALID afterwards.
REQ-040 A reset asserted mid-lock releases the lock with no LOCK_ERR.

Verification
REQ-041 P0 writes A=0x10 WE=1111 DI=0xDEADBEEF, then reads 0x10 -> P0_RVALID=1 one cycle after the read accept with P0_DO=0xDEADBEEF; P1_RVALID stays 0.
REQ-042 Both ports continuously valid, FIXED_PRIO=0, 6 cycles -> grants 0,1,0,1,0,1 and EN0=1 every cycle; with FIXED_PRIO=1 -> grants all port 0.
REQ-043 Byte enables: write 0x11223344 to 0x20, then WE=0100 DI=0xAAAAAAAA -> read returns 0x11AA3344.
REQ-044 P1 LOCK=1 accept, then P1 idle while P0 is valid, LOCK_TIMEOUT=16 -> P0_READY=0 for 16 cycles, LOCK_ERR pulses once, P0 is accepted in the next cycle.
REQ-045 P0 LOCK=1 read, then P0 LOCK=0 write while P1 is valid throughout -> P1 is blocked for both transfers and granted in the following cycle.
REQ-046 RST pulsed while in LOCK1 with a read accepted in the same cycle -> no RVALID, state FREE, LOCK_ERR=0, port 0 wins the first contended cycle.
